spi_byte_fifo: RTL

SPI_BYTE_FIFO -- requirements
Module: spi_byte_fifo

---
 rtl/spi_byte_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - TX/RX byte FIFOs sequencing bytes through an SPI master register port
// Define SPI_BYTE_FIFO_IRQ_EN to enable the o_int interrupt output and CTRL.ie.
module spi_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_wr,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_int,
    output logic       o_spi_en,
    output logic       o_spi_wr,
    output logic [3:0] o_spi_addr,
    output logic [7:0] o_spi_data,
    input  logic [7:0] i_spi_data,
    input  logic       i_spi_int
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_FETCH, S_CAPT, S_PUSH} state_t;

    state_t      r_state;
    logic [7:0]  r_tx_mem [DEPTH];
    logic [7:0]  r_rx_mem [DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic        r_run, r_tx_ovf, r_rx_unf, r_fwd_pend, r_drop;
    logic [7:0]  r_fwd_data, r_capt;

    logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic       w_wr_tx, w_wr_ctrl, w_wr_spi, w_rd_rx, w_flush;
    logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_start, w_ie;
    logic [7:0] w_status, w_ctrl;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

    assign w_wr_tx   = i_en & i_wr & (i_addr == 4'h1);
    assign w_wr_ctrl = i_en & i_wr & (i_addr == 4'h3);
    assign w_wr_spi  = i_en & i_wr & (i_addr == 4'h4);
    assign w_rd_rx   = i_en & ~i_wr & (i_addr == 4'h2);
    assign w_flush   = w_wr_ctrl & i_data[1];

    assign w_tx_push = w_wr_tx & ~w_tx_full;
    assign w_tx_pop  = (r_state == S_LOAD);
    assign w_rx_push = (r_state == S_PUSH) & ~r_drop;
    assign w_rx_pop  = w_rd_rx & ~w_rx_empty;
    // A flush in the same cycle must not launch a byte that is about to be discarded.
    assign w_start   = r_run & ~w_tx_empty & ~w_rx_full & ~r_fwd_pend & ~w_flush;

    assign w_status = {1'b0, r_rx_unf, r_tx_ovf, (r_state != S_IDLE),
                       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
    assign w_ctrl   = {5'b0, w_ie, 1'b0, r_run};

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= i_data;
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_capt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else if (w_flush) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run    <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
            o_data   <= 8'h00;
        end else begin
            if (w_wr_tx & w_tx_full)  r_tx_ovf <= 1'b1;
            if (w_rd_rx & w_rx_empty) r_rx_unf <= 1'b1;
            if (w_wr_ctrl) begin
                r_run <= i_data[0];
                if (i_data[7]) begin
                    r_tx_ovf <= 1'b0;
                    r_rx_unf <= 1'b0;
                end
            end
            if (i_en & ~i_wr) begin
                case (i_addr)
                    4'h0:    o_data <= w_status;
                    4'h2:    o_data <= w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
                    4'h3:    o_data <= w_ctrl;
                    default: o_data <= 8'h00;
                endcase
            end
        end
    end

`ifdef SPI_BYTE_FIFO_IRQ_EN
    logic r_ie;
    assign w_ie = r_ie;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ie  <= 1'b0;
            o_int <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ie <= i_data[2];
            o_int <= r_ie & (~w_rx_empty | r_tx_ovf);
        end
    end
`else
    assign w_ie  = 1'b0;
    assign o_int = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            o_spi_en   <= 1'b0;
            o_spi_wr   <= 1'b0;
            o_spi_addr <= 4'h0;
            o_spi_data <= 8'h00;
            r_fwd_pend <= 1'b0;
            r_fwd_data <= 8'h00;
            r_drop     <= 1'b0;
            r_capt     <= 8'h00;
        end else begin
            o_spi_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_fwd_pend) begin
                        o_spi_en   <= 1'b1;
                        o_spi_wr   <= 1'b1;
                        o_spi_addr <= 4'h3;
                        o_spi_data <= r_fwd_data;
                        r_fwd_pend <= 1'b0;
                    end else if (w_start) begin
                        o_spi_en   <= 1'b1;
                        o_spi_wr   <= 1'b1;
                        o_spi_addr <= 4'h1;
                        o_spi_data <= r_tx_mem[r_tx_rp[AW-1:0]];
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_spi_int) begin
                        o_spi_en   <= 1'b1;
                        o_spi_wr   <= 1'b0;
                        o_spi_addr <= 4'h2;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CAPT;
                S_CAPT: begin
                    r_capt  <= i_spi_data;
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    r_drop  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // The in-flight byte still runs on SPI after a flush, but never lands in RX.
            if (w_flush && r_state != S_IDLE && r_state != S_PUSH) r_drop <= 1'b1;
            if (w_wr_spi) begin
                r_fwd_pend <= 1'b1;
                r_fwd_data <= i_data;
            end
        end
    end
endmodule
